// File: rtl/block_mult_scheduler_if.sv
// Control bus between the tiled-multiply scheduler and the block RAM,
// block multiplier and 2x2 accumulator it sequences.
interface block_mult_scheduler_if #(
  parameter int AW = 8
);
  logic          start;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] a_addr;
  logic [AW-1:0] b_addr;
  logic          mul_start;
  logic          mul_done;
  logic          acc_clr;
  logic          acc_start;
  logic          acc_done;
  logic          c_we;
  logic [AW-1:0] c_addr;

  modport master (
    output start, mul_done, acc_done,
    input  busy, done, err, a_addr, b_addr, mul_start, acc_clr, acc_start,
           c_we, c_addr
  );

  modport slave (
    input  start, mul_done, acc_done,
    output busy, done, err, a_addr, b_addr, mul_start, acc_clr, acc_start,
           c_we, c_addr
  );
endinterface

// File: rtl/block_mult_scheduler.sv
// Sequencer for C = A*B over NB x NB grids of 2x2 blocks: walks (i,j,k),
// drives block RAM addresses and the multiplier/accumulator handshakes.
module block_mult_scheduler #(
  parameter int w   = 32,
  parameter int NB  = 2,
  parameter int AW  = 8,
  parameter int TMO = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  block_mult_scheduler_if.slave bus
);

  localparam int CW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int WDW = ($clog2(TMO + 1) > 8) ? $clog2(TMO + 1) : 8;
  localparam logic [CW-1:0]  IDX_LAST = CW'(NB - 1);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TMO - 1);
  localparam logic [AW-1:0]  NB_A     = AW'(NB);

  if (w < 1 || NB < 1 || NB > 16 || TMO < 1 || (64'd1 << AW) < 64'(NB * NB)) begin : g_cfg_check
    $error("block_mult_scheduler: illegal parameter combination");
  end

  typedef enum logic [3:0] {
    IDLE, CLR, CLR_W, FETCH, MUL, MUL_W, ACC, ACC_W, WR, DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
  logic           busy_q, done_q, mul_start_q, acc_clr_q, acc_start_q, c_we_q;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    wd_d    = wd_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = CLR;
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        err_d   = 1'b0;
      end
      CLR:   state_d = CLR_W;
      CLR_W: state_d = FETCH;
      FETCH: state_d = MUL;
      MUL: begin
        state_d = MUL_W;
        wd_d    = '0;
      end
      MUL_W: begin
        if (bus.mul_done) begin
          state_d = ACC;
        end else if (wd_q == WD_LAST) begin
          // Watchdog abort: drop the partial block and park in IDLE.
          state_d = IDLE;
          err_d   = 1'b1;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ACC: begin
        state_d = ACC_W;
        wd_d    = '0;
      end
      ACC_W: begin
        if (bus.acc_done) begin
          if (k_q != IDX_LAST) begin
            k_d     = k_q + 1'b1;
            state_d = FETCH;
          end else begin
            k_d     = '0;
            state_d = WR;
          end
        end else if (wd_q == WD_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      WR: begin
        if (j_q == IDX_LAST) begin
          j_d = '0;
          if (i_q == IDX_LAST) begin
            i_d     = '0;
            state_d = DONE;
          end else begin
            i_d     = i_q + 1'b1;
            state_d = CLR;
          end
        end else begin
          j_d     = j_q + 1'b1;
          state_d = CLR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so each is high exactly
  // while the FSM sits in the matching state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mul_start_q <= 1'b0;
      acc_clr_q   <= 1'b0;
      acc_start_q <= 1'b0;
      c_we_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
      mul_start_q <= (state_d == MUL);
      acc_clr_q   <= (state_d == CLR);
      acc_start_q <= (state_d == ACC);
      c_we_q      <= (state_d == WR);
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.mul_start = mul_start_q;
  assign bus.acc_clr   = acc_clr_q;
  assign bus.acc_start = acc_start_q;
  assign bus.c_we      = c_we_q;
  assign bus.a_addr    = AW'(i_q) * NB_A + AW'(k_q);
  assign bus.b_addr    = AW'(k_q) * NB_A + AW'(j_q);
  assign bus.c_addr    = AW'(i_q) * NB_A + AW'(j_q);

endmodule

// File: tb/tb_block_mult_scheduler.sv
// Directed bench: NB=2 and NB=1 schedulers driven by a fixed-latency
// multiplier/accumulator model and a 4x4 integer matrix product model.
module tb_block_mult_scheduler;
  localparam int AW  = 8;
  localparam int LM  = 3;
  localparam int LA  = 2;
  localparam int TMO = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  block_mult_scheduler_if #(.AW(AW)) if0 ();
  block_mult_scheduler_if #(.AW(AW)) if1 ();

  block_mult_scheduler #(.w(32), .NB(2), .AW(AW), .TMO(TMO)) u0 (
    .clk(clk), .reset(reset), .bus(if0)
  );
  block_mult_scheduler #(.w(32), .NB(1), .AW(AW), .TMO(TMO)) u1 (
    .clk(clk), .reset(reset), .bus(if1)
  );

  typedef struct {
    int step;
    int exp_a;
    int exp_b;
  } ab_vec_t;

  ab_vec_t ab_tab[8];
  int      c_tab[4];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshake partner model and monitor state
  int mcnt = 0, acnt = 0;
  bit mul_en = 1'b1, spur_mul = 1'b0;
  int mstart_cnt = 0, astart_cnt = 0, clr_cnt = 0, cwe_cnt = 0, done_cnt = 0;
  int done_cyc = 0;
  int alog[$], blog[$], clog[$];
  int Am[4][4], Bm[4][4], Cm[4][4];
  int accm[2][2], prod[2][2];

  always @(negedge clk) begin
    logic ms, as, clr, we, in_accw, md, ad;
    int a, b, c;
    ms  = if0.mul_start | if1.mul_start;
    as  = if0.acc_start | if1.acc_start;
    clr = if0.acc_clr | if1.acc_clr;
    we  = if0.c_we | if1.c_we;
    a   = if0.mul_start ? int'(if0.a_addr) : int'(if1.a_addr);
    b   = if0.mul_start ? int'(if0.b_addr) : int'(if1.b_addr);
    c   = if0.c_we ? int'(if0.c_addr) : int'(if1.c_addr);
    in_accw = (acnt > 0) && !as;
    if (as) begin
      acnt = LA; ad = 1'b0;
    end else if (acnt > 0) begin
      acnt--; ad = (acnt == 0);
    end else ad = 1'b0;
    if (ms) begin
      mcnt = LM; md = 1'b0;
    end else if (mcnt > 0) begin
      mcnt--; md = (mcnt == 0) && mul_en;
    end else md = spur_mul && in_accw;
    if0.mul_done = md; if1.mul_done = md;
    if0.acc_done = ad; if1.acc_done = ad;

    if (clr) begin
      clr_cnt++;
      for (int r = 0; r < 2; r++) for (int q = 0; q < 2; q++) accm[r][q] = 0;
    end
    if (ms) begin
      mstart_cnt++;
      alog.push_back(a);
      blog.push_back(b);
      if (a < 4 && b < 4)
        for (int r = 0; r < 2; r++)
          for (int q = 0; q < 2; q++) begin
            prod[r][q] = 0;
            for (int t = 0; t < 2; t++)
              prod[r][q] += Am[2*(a/2)+r][2*(a%2)+t] * Bm[2*(b/2)+t][2*(b%2)+q];
          end
    end
    if (as) begin
      astart_cnt++;
      for (int r = 0; r < 2; r++) for (int q = 0; q < 2; q++) accm[r][q] += prod[r][q];
    end
    if (we) begin
      cwe_cnt++;
      clog.push_back(c);
      if (c < 4)
        for (int r = 0; r < 2; r++)
          for (int q = 0; q < 2; q++) Cm[2*(c/2)+r][2*(c%2)+q] = accm[r][q];
    end
    if (if0.done | if1.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sel_cnt(input int which);
    case (which)
      0:       return mstart_cnt;
      1:       return astart_cnt;
      default: return done_cnt;
    endcase
  endfunction

  task automatic wait_evt(input string nm, input int which, input int target, input int limit);
    int n = 0;
    while (sel_cnt(which) < target && n < limit) begin
      step();
      n++;
    end
    if (sel_cnt(which) < target) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: event count %0d required %0d within %0d cycles", nm, sel_cnt(which), target, limit);
    end
  endtask

  task automatic start_pulse(input int which, output int t0);
    t0 = cyc;
    if (which == 0) if0.start = 1'b1; else if1.start = 1'b1;
    step();
    if0.start = 1'b0;
    if1.start = 1'b0;
  endtask

  task automatic clear_logs();
    alog.delete(); blog.delete(); clog.delete();
    for (int r = 0; r < 4; r++) for (int q = 0; q < 4; q++) Cm[r][q] = -1;
  endtask

  task automatic check_schedule(input string nm);
    chk({nm, "_fetches"}, alog.size(), 8);
    for (int n = 0; n < 8 && n < alog.size(); n++)
      chk($sformatf("%s_ab%0d", nm, ab_tab[n].step), alog[n] * 256 + blog[n],
          ab_tab[n].exp_a * 256 + ab_tab[n].exp_b);
    chk({nm, "_writes"}, clog.size(), 4);
    for (int n = 0; n < 4 && n < clog.size(); n++)
      chk($sformatf("%s_caddr%0d", nm, n), clog[n], c_tab[n]);
  endtask

  initial begin
    int t0, mb, cb, db;
    #100000;
    $display("FAIL global_timeout: simulation time %0t exceeded", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    int t0, mb, cb, db, ab;
    ab_tab[0] = '{0, 0, 0}; ab_tab[1] = '{1, 1, 2};
    ab_tab[2] = '{2, 0, 1}; ab_tab[3] = '{3, 1, 3};
    ab_tab[4] = '{4, 2, 0}; ab_tab[5] = '{5, 3, 2};
    ab_tab[6] = '{6, 2, 1}; ab_tab[7] = '{7, 3, 3};
    c_tab = '{0, 1, 2, 3};
    for (int r = 0; r < 4; r++)
      for (int q = 0; q < 4; q++) begin
        Am[r][q] = r * 4 + q + 1;
        Bm[r][q] = (r == q) ? 1 : 0;
      end

    reset = 1'b0;
    if0.start = 1'b0;
    if1.start = 1'b0;
    repeat (3) step();
    chk("reset_ctrl", {if0.busy, if0.done, if0.err, if0.mul_start, if0.acc_clr, if0.acc_start, if0.c_we}, 0);
    chk("reset_addr", {if0.a_addr, if0.b_addr, if0.c_addr}, 0);
    chk("reset_nb1_busy", {if1.busy, if1.done, if1.err}, 0);
    reset = 1'b1;
    step();

    // Nominal NB=2 run with A=[1..16], B=I
    clear_logs();
    db = done_cnt;
    start_pulse(0, t0);
    chk("busy_after_start", if0.busy, 1);
    wait_evt("nominal_done", 2, db + 1, 200);
    chk("nominal_done_time", done_cyc - t0, 77);
    chk("nominal_idle", {if0.busy, if0.err}, 0);
    check_schedule("nominal");
    for (int r = 0; r < 4; r++)
      for (int q = 0; q < 4; q++)
        chk($sformatf("c_elem_%0d_%0d", r, q), Cm[r][q], r * 4 + q + 1);

    // Reset during the second MUL_W of block (0,1)
    clear_logs();
    mb = mstart_cnt;
    cb = cwe_cnt;
    start_pulse(0, t0);
    wait_evt("midrst_reach", 0, mb + 4, 200);
    chk("midrst_pre_addr", {if0.a_addr, if0.b_addr}, {8'd1, 8'd3});
    reset = 1'b0;
    step();
    chk("midrst_ctrl", {if0.busy, if0.done, if0.err, if0.mul_start, if0.acc_clr, if0.acc_start, if0.c_we}, 0);
    chk("midrst_addr", {if0.a_addr, if0.b_addr, if0.c_addr}, 0);
    reset = 1'b1;
    repeat (30) step();
    chk("midrst_no_we", cwe_cnt - cb, 1);
    chk("midrst_idle", if0.busy, 0);
    clear_logs();
    db = done_cnt;
    start_pulse(0, t0);
    wait_evt("midrst_restart_done", 2, db + 1, 200);
    chk("midrst_restart_time", done_cyc - t0, 77);
    check_schedule("restart");

    // Watchdog on a missing mul_done
    mul_en = 1'b0;
    mb = mstart_cnt;
    db = done_cnt;
    start_pulse(0, t0);
    wait_evt("wd_reach_mulw", 0, mb + 1, 50);
    for (int t = 1; t <= 10; t++) begin
      step();
      if (t == 9) chk("wd_not_yet", {if0.err, if0.busy}, 2'b01);
      if (t == 10) chk("wd_fire", {if0.err, if0.busy}, 2'b10);
    end
    repeat (5) step();
    chk("wd_sticky", if0.err, 1);
    chk("wd_no_done", done_cnt - db, 0);
    mul_en = 1'b1;
    start_pulse(0, t0);
    chk("wd_err_cleared", {if0.err, if0.busy}, 2'b01);
    wait_evt("wd_recover_done", 2, db + 1, 200);

    // start and a stray mul_done during ACC_W must be ignored
    repeat (3) step();
    clear_logs();
    ab = astart_cnt;
    db = done_cnt;
    start_pulse(0, t0);
    wait_evt("ign_reach_accw", 1, ab + 1, 50);
    if0.start = 1'b1;
    spur_mul = 1'b1;
    step();
    if0.start = 1'b0;
    wait_evt("ign_done", 2, db + 1, 200);
    spur_mul = 1'b0;
    chk("ign_done_time", done_cyc - t0, 77);
    check_schedule("ignored");
    repeat (3) step();
    chk("ign_no_relaunch", if0.busy, 0);

    // NB=1 single pass
    clear_logs();
    mb = mstart_cnt; ab = astart_cnt; cb = clr_cnt; db = done_cnt;
    start_pulse(1, t0);
    wait_evt("nb1_done", 2, db + 1, 100);
    chk("nb1_done_time", done_cyc - t0, 12);
    chk("nb1_counts", {8'(clr_cnt - cb), 8'(mstart_cnt - mb), 8'(astart_cnt - ab)}, 24'h010101);
    chk("nb1_writes", clog.size(), 1);
    if (clog.size() > 0) chk("nb1_caddr", clog[0], 0);
    chk("nb1_idle", {if1.busy, if1.err, if0.busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/block_mult_scheduler.md
# block_mult_scheduler

Sequencer for tiled matrix multiplication. C = A·B over NB×NB grids of 2×2 blocks. For every output block C(i,j) it clears the 2×2 accumulator, then loops k over the block row and column:
- fetches A(i,k) and B(k,j) from block RAM,
- starts the 2×2 block multiplier,
- feeds the product to the accumulator,
- writes the finished C(i,j) back.

It sits above the block multiplier and the 2×2 accumulator and owns all of their control handshakes.

## Interface
- w, 32: element width. Informational only; the scheduler carries no data.
- NB, 2: blocks per matrix dimension, 1..16.
- AW, 8: block-address width. Must satisfy 2^AW ≥ NB·NB.
- TMO, 255: watchdog limit in cycles for any wait on mul_done or acc_done.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low; asserted when 0.
- start  in  1  begin a full multiply; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the full product has been written.
- err  out  1  sticky watchdog flag; cleared on reset or on an accepted start.
- a_addr  out  AW  A block address, i·NB+k.
- b_addr  out  AW  B block address, k·NB+j.
- Block RAM read latency is 1 cycle.
- mul_start  out  1  one-cycle pulse to the block multiplier.
- mul_done  in  1  multiplier result valid; pulse or level both accepted.
- acc_clr  out  1  one-cycle accumulator clear; the accumulator's reset is active-high.
- acc_start  out  1  one-cycle pulse; accumulator adds the current product.
- acc_done  in  1  accumulator update complete, one-cycle pulse.
- c_we  out  1  one-cycle write strobe for the accumulator outputs.
- c_addr  out  AW  C block address, i·NB+j.

## Operation
- Counters i, j, k, each ⌈log2 NB⌉ bits (minimum 1 bit). All three are 0 in IDLE.
- Addresses are combinational from the registered counters.
- Reset value of every output is 0.

States and transitions:
- IDLE: wait for start=1, then clear i, j, k and err, and go to CLR.
- CLR: acc_clr=1, then go to CLR_W.
- CLR_W: one cycle, so the accumulator returns to idle; then go to FETCH.
- FETCH: a_addr and b_addr are presented; go to MUL.
- MUL: mul_start=1; RAM data is valid this cycle; go to MUL_W.
- MUL_W: wait for mul_done=1, then go to ACC.
- ACC: acc_start=1, then go to ACC_W.
- ACC_W: wait for acc_done=1.
  - If k<NB-1: k++ and go to FETCH. The FETCH cycle provides the accumulator's one-cycle recovery gap.
  - Otherwise: k=0 and go to WR.
- WR: c_we=1 with c_addr = i·NB+j. Then advance j and i:
  - j++; on wrap j=0 and i++.
  - If i=NB-1 and j=NB-1 before the advance, go to DONE; otherwise go to CLR.
- DONE: done=1, then go to IDLE.

Rules:
- Order of output blocks is row-major: (0,0), (0,1), …, (NB-1,NB-1).
- Watchdog: an 8-bit-or-wider counter runs in MUL_W and ACC_W and resets on entry to either state.
  - On reaching TMO: err=1, the block moves to IDLE, and done is not pulsed.
- start while busy is ignored. start held high through DONE re-launches on the cycle after returning to IDLE.
- mul_done or acc_done arriving outside their wait states is ignored.
- reset=0 in any state: go to IDLE at the next edge and zero all outputs and counters. No writeback for the partial block.
- NB=1: a single pass CLR→…→WR→DONE.

## Timing
Latency definitions:
- Lm = MUL_W cycles, inclusive of the cycle in which mul_done is seen.
- La = ACC_W cycles, defined the same way for acc_done.

Cycle counts:
- Per k-step: 3 + Lm + La cycles (FETCH, MUL, ACC, plus the waits).
- Per output block: 2 + NB·(3+Lm+La) + 1 cycles.
- Total from the start-sampled edge to the done pulse: NB²·(3 + NB·(3+Lm+La)) + 1 cycles.

Signal timing:
- a_addr and b_addr are held stable from FETCH through MUL.
- c_addr is stable in WR only and is don't-care elsewhere, though it is driven from the counters.
- Outputs are registered or decoded from the registered state; no input drives an output combinationally.

## Test plan
- **NB=2, model mul Lm=3, acc La=2, start one cycle:**
  - a_addr/b_addr sequence is (0,0),(1,2), (0,1),(1,3), (2,0),(3,2), (2,1),(3,3).
  - c_we fires 4 times with c_addr 0,1,2,3.
  - done arrives exactly 4·(3+2·8)+1 = 77 cycles after start.
- **Functional product, NB=2, integer A=[1..16] layout, B=identity:** written C blocks equal the A blocks.
- **Reset mid-op:** drive reset=0 during the second MUL_W of block (0,1).
  - Next edge: busy=0, and all outputs are 0.
  - No further c_we.
  - A fresh start completes normally with 4 writes.
- **Watchdog, TMO=10:** mul_done never asserted.
  - err=1 exactly 10 cycles after MUL_W entry; busy=0; done stays 0.
  - The next start clears err.
- **start ignored while busy:** pulse start during ACC_W.
  - Address sequence and done time are identical to scenario 1.
  - A spurious mul_done in ACC_W has no effect.
- **NB=1:** one CLR, one FETCH/MUL/ACC, c_we at c_addr 0, done at 3+(3+Lm+La)+1 cycles.
